// File: rtl/reaction_if.sv
// Signal bundle between the reaction-game stimulus side and reaction_fsm.
// best_ms exists only when REACTION_BEST_EN is defined.
interface reaction_if #(
  parameter int RESULT_W = 14
);
  logic                start;
  logic                react;
  logic                delay_done;
  logic                timer_reset_n;
  logic                led;
  logic [RESULT_W-1:0] result_ms;
  logic                result_valid;
  logic                early;
  logic                timeout;
`ifdef REACTION_BEST_EN
  logic [RESULT_W-1:0] best_ms;
`endif

  modport master (
    output start, react, delay_done,
`ifdef REACTION_BEST_EN
    input  best_ms,
`endif
    input  timer_reset_n, led, result_ms, result_valid, early, timeout
  );

  modport slave (
    input  start, react, delay_done,
`ifdef REACTION_BEST_EN
    output best_ms,
`endif
    output timer_reset_n, led, result_ms, result_valid, early, timeout
  );
endinterface

// File: rtl/reaction_fsm.sv
// Reaction-time game control: arms the delay timer, measures response in ms,
// flags false starts and timeouts. Define REACTION_BEST_EN to add best_ms tracking.
module reaction_fsm #(
  parameter int CLKS_PER_MS  = 50000,
  parameter int MAX_REACT_MS = 9999,
  parameter int RESULT_W     = 14
) (
  input  logic       clk,
  input  logic       reset,
  reaction_if.slave  bus
);

  localparam int CYC_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [CYC_W-1:0]    CYC_LAST = CYC_W'(CLKS_PER_MS - 1);
  localparam logic [RESULT_W-1:0] MS_MAX   = RESULT_W'(MAX_REACT_MS);

  typedef enum logic [2:0] {IDLE, ARMED, GO, DONE, FOUL} state_t;

  state_t              state, state_nxt;
  logic                start_q, react_q;
  logic                start_rise, react_rise;
  logic [CYC_W-1:0]    cyc_cnt, cyc_nxt;
  logic [RESULT_W-1:0] ms_cnt, ms_nxt;
  logic [RESULT_W-1:0] result_q, result_nxt;
  logic                timeout_q, timeout_nxt;
  logic                wrap;

  function automatic logic [RESULT_W-1:0] ms_sat_inc(input logic [RESULT_W-1:0] v);
    return (v >= MS_MAX) ? MS_MAX : v + RESULT_W'(1);
  endfunction

  assign start_rise = bus.start & ~start_q;
  assign react_rise = bus.react & ~react_q;
  assign wrap       = (cyc_cnt == CYC_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      react_q   <= 1'b0;
      cyc_cnt   <= '0;
      ms_cnt    <= '0;
      result_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      start_q   <= bus.start;
      react_q   <= bus.react;
      cyc_cnt   <= cyc_nxt;
      ms_cnt    <= ms_nxt;
      result_q  <= result_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cyc_nxt     = cyc_cnt;
    ms_nxt      = ms_cnt;
    result_nxt  = result_q;
    timeout_nxt = timeout_q;
    case (state)
      IDLE: begin
        if (start_rise) state_nxt = ARMED;
      end
      ARMED: begin
        // A press before the go event is a foul even if go arrives together.
        if (react_rise) begin
          state_nxt = FOUL;
        end else if (bus.delay_done) begin
          state_nxt = GO;
          cyc_nxt   = '0;
          ms_nxt    = '0;
        end
      end
      GO: begin
        cyc_nxt = wrap ? '0 : cyc_cnt + CYC_W'(1);
        if (wrap) ms_nxt = ms_sat_inc(ms_cnt);
        // The press samples ms_cnt before this cycle's increment and beats timeout.
        if (react_rise) begin
          result_nxt  = ms_cnt;
          timeout_nxt = 1'b0;
          state_nxt   = DONE;
        end else if (ms_nxt == MS_MAX) begin
          result_nxt  = MS_MAX;
          timeout_nxt = 1'b1;
          state_nxt   = DONE;
        end
      end
      DONE, FOUL: begin
        if (start_rise) begin
          state_nxt   = ARMED;
          timeout_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef REACTION_BEST_EN
  logic [RESULT_W-1:0] best_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      best_q <= '1;
    end else if (state != DONE && state_nxt == DONE && !timeout_nxt && result_nxt < best_q) begin
      best_q <= result_nxt;
    end
  end

  assign bus.best_ms = best_q;
`endif

  assign bus.timer_reset_n = (state == ARMED);
  assign bus.led           = (state == GO);
  assign bus.result_valid  = (state == DONE);
  assign bus.early         = (state == FOUL);
  assign bus.result_ms     = result_q;
  assign bus.timeout       = timeout_q;

endmodule

// File: tb/tb_reaction_fsm.sv
// Scoreboard bench for reaction_fsm with CLKS_PER_MS=4, MAX_REACT_MS=20.
// Build with REACTION_BEST_EN defined to also cover best_ms.
module tb_reaction_fsm;

  localparam int RW = 14;

  logic clk;
  logic reset;

  reaction_if #(.RESULT_W(RW)) bus ();

  reaction_fsm #(
    .CLKS_PER_MS (4),
    .MAX_REACT_MS(20),
    .RESULT_W    (RW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    bit is_early;
    int ms;
    bit to;
    int best;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   fails  = 0;
  logic rv_prev = 1'b0;
  logic early_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input bit is_early, input int ms, input bit to, input int best);
    exp_t x;
    x.is_early = is_early;
    x.ms       = ms;
    x.to       = to;
    x.best     = best;
    exp_q.push_back(x);
  endtask

  task automatic arm();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic go();
    bus.delay_done = 1'b1;
    step(1);
    bus.delay_done = 1'b0;
  endtask

  // React rise sampled k edges after the led rose.
  task automatic react_at(input int k, input int ms, input int best);
    step(k - 1);
    bus.react = 1'b1;
    push(1'b0, ms, 1'b0, best);
    step(1);
    bus.react = 1'b0;
  endtask

  task automatic run_timeout(input int best);
    step(79);
    chk("go_before_timeout_valid", bus.result_valid, 0);
    push(1'b0, 20, 1'b1, best);
    step(1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_timer_reset_n"}, bus.timer_reset_n, 0);
    chk({tag, "_led"}, bus.led, 0);
    chk({tag, "_result_ms"}, bus.result_ms, 0);
    chk({tag, "_result_valid"}, bus.result_valid, 0);
    chk({tag, "_early"}, bus.early, 0);
    chk({tag, "_timeout"}, bus.timeout, 0);
`ifdef REACTION_BEST_EN
    chk({tag, "_best_ms"}, bus.best_ms, (1 << RW) - 1);
`endif
  endtask

  // Monitor: each new result or foul presentation consumes one expectation.
  always @(negedge clk) begin
    if (!reset) begin
      rv_prev    = 1'b0;
      early_prev = 1'b0;
    end else begin
      if ((bus.result_valid && !rv_prev) || (bus.early && !early_prev)) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_output: valid=%0d early=%0d with empty scoreboard",
                   bus.result_valid, bus.early);
        end else begin
          e = exp_q.pop_front();
          chk("sb_early", bus.early, e.is_early);
          if (!e.is_early) begin
            chk("sb_result_ms", bus.result_ms, e.ms);
            chk("sb_timeout", bus.timeout, e.to);
`ifdef REACTION_BEST_EN
            chk("sb_best_ms", bus.best_ms, e.best);
`endif
          end
        end
      end
      rv_prev    = bus.result_valid;
      early_prev = bus.early;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    reset          = 1'b0;
    bus.start      = 1'b0;
    bus.react      = 1'b0;
    bus.delay_done = 1'b0;
    step(2);
    chk_reset_outputs("reset");
    reset = 1'b1;
    step(1);

    // Normal round: 30 edges after led rise -> 7 ms
    chk("idle_timer_reset_n", bus.timer_reset_n, 0);
    arm();
    chk("armed_timer_reset_n", bus.timer_reset_n, 1);
    chk("armed_led", bus.led, 0);
    step(2);
    go();
    chk("go_led", bus.led, 1);
    chk("go_timer_reset_n", bus.timer_reset_n, 0);
    react_at(30, 7, 7);
    chk("done_led", bus.led, 0);
    chk("done_valid", bus.result_valid, 1);

    // False start
    arm();
    step(1);
    bus.react = 1'b1;
    push(1'b1, 0, 1'b0, 0);
    step(1);
    bus.react = 1'b0;
    chk("foul_early", bus.early, 1);
    chk("foul_timer_reset_n", bus.timer_reset_n, 0);
    step(2);
    chk("foul_led", bus.led, 0);
    arm();
    chk("rearm_early", bus.early, 0);
    chk("rearm_timer_reset_n", bus.timer_reset_n, 1);

    // react rise and delay_done together -> foul
    bus.react      = 1'b1;
    bus.delay_done = 1'b1;
    push(1'b1, 0, 1'b0, 0);
    step(1);
    bus.react      = 1'b0;
    bus.delay_done = 1'b0;
    chk("tie_foul_early", bus.early, 1);
    chk("tie_foul_led", bus.led, 0);

    // Timeout
    arm();
    go();
    run_timeout(7);
    chk("timeout_flag", bus.timeout, 1);
    chk("timeout_valid", bus.result_valid, 1);

    // React on a wrap from ms_cnt=5
    arm();
    chk("arm_clears_timeout", bus.timeout, 0);
    go();
    react_at(24, 5, 5);

    // React on the same edge the timeout would fire
    arm();
    go();
    react_at(80, 19, 5);
    chk("react_beats_timeout", bus.timeout, 0);

    // React held across starts gives one event only
    arm();
    bus.react = 1'b1;
    push(1'b1, 0, 1'b0, 0);
    step(1);
    chk("held_first_foul", bus.early, 1);
    arm();
    step(3);
    chk("held_no_refoul", bus.early, 0);
    chk("held_armed", bus.timer_reset_n, 1);
    bus.react = 1'b0;
    step(1);
    go();
    react_at(10, 2, 2);

    // Asynchronous reset mid-GO
    arm();
    go();
    step(5);
    chk("pre_reset_led", bus.led, 1);
    #3;
    reset = 1'b0;
    #1;
    chk_reset_outputs("async");
    step(1);
    reset = 1'b1;
    go();
    chk("post_reset_idle_led", bus.led, 0);
    chk("post_reset_idle_trn", bus.timer_reset_n, 0);
    arm();
    chk("post_reset_arm", bus.timer_reset_n, 1);

`ifdef REACTION_BEST_EN
    // Results 9, 5, timeout, 7 -> best 9, 5, 5, 5
    go();
    react_at(37, 9, 9);
    arm();
    go();
    react_at(21, 5, 5);
    arm();
    go();
    run_timeout(5);
    arm();
    go();
    react_at(29, 7, 5);
`endif

    step(3);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
